writeback_queue: RTL

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue.sv | 97 +++++++++
 1 files changed

// File: rtl/writeback_queue.sv
// Writeback queue: a circular FIFO of pending register-file writes.
// It drains one entry per free write-port cycle and forwards the youngest pending value on lookup.
package wbq_pkg;
    localparam int REG_WIDTH  = 5;
    localparam int DATA_WIDTH = 32;
endpackage

module writeback_queue
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    _CLK,
    input  logic                    _RESET,
    input  logic                    _wbValid,
    input  logic [REG_WIDTH-1:0]    _wbDest,
    input  logic [DATA_WIDTH-1:0]   _wbVal,
    output logic                    wbReady,
    input  logic                    _portBusy,
    output logic                    regWrite,
    output logic [REG_WIDTH-1:0]    regDest,
    output logic [DATA_WIDTH-1:0]   writeVal,
    input  logic [REG_WIDTH-1:0]    _lookupReg,
    output logic                    lookupHit,
    output logic [DATA_WIDTH-1:0]   lookupVal,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [REG_WIDTH-1:0]  r_dest [DEPTH];
    logic [DATA_WIDTH-1:0] r_val  [DEPTH];
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;

    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_hit;
    logic [DATA_WIDTH-1:0] w_hitVal;

    // Ready depends only on occupancy, never on a same-cycle drain.
    assign w_empty  = (r_count == '0);
    assign wbReady  = (r_count < CW'(DEPTH));
    assign w_push   = _wbValid && wbReady;
    assign regWrite = !w_empty && !_portBusy;
    assign w_pop    = regWrite;
    assign regDest  = w_empty ? '0 : r_dest[r_head];
    assign writeVal = w_empty ? '0 : r_val[r_head];
    assign count    = r_count;
    assign lookupHit = w_hit;
    assign lookupVal = w_hitVal;

    // Pointers and occupancy; reset discards everything pending.
    always_ff @(posedge _CLK or posedge _RESET) begin
        if (_RESET) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage needs no reset; occupancy decides which slots are live.
    always_ff @(posedge _CLK) begin
        if (w_push) begin
            r_dest[r_tail] <= _wbDest;
            r_val[r_tail]  <= _wbVal;
        end
    end

    // Scan oldest to youngest so the youngest live match wins.
    always_comb begin
        w_hit    = 1'b0;
        w_hitVal = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] idx;
            idx = r_head + PW'(i);
            if ((CW'(i) < r_count) && (r_dest[idx] == _lookupReg)) begin
                w_hit    = 1'b1;
                w_hitVal = r_val[idx];
            end
        end
    end
endmodule
